// File: rtl/commit_chk_pkg.sv
// Shared types and constants for the commit stream checker.
package commit_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam int unsigned ERR_W = 3;

  localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 3'd1;
  localparam logic [ERR_W-1:0] ERR_PC      = 3'd2;
  localparam logic [ERR_W-1:0] ERR_RD      = 3'd3;
  localparam logic [ERR_W-1:0] ERR_DATA    = 3'd4;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd5;

endpackage

// File: rtl/commit_exp_ram.sv
// Expected-commit table: one synchronous write port, one asynchronous read port, no reset.
module commit_exp_ram #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wpc,
  input  logic [4:0]        wrd,
  input  logic [XLEN-1:0]   wdata,
  input  logic [AW-1:0]     raddr,
  output logic [XLEN-1:0]   rpc,
  output logic [4:0]        rrd,
  output logic [XLEN-1:0]   rdata
);

  localparam int unsigned EW = XLEN + 5 + XLEN;

  logic [EW-1:0] mem_q [DEPTH];

  // Table write; contents survive reset so a run can be repeated without reloading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= {wpc, wrd, wdata};
    end
  end

  assign {rpc, rrd, rdata} = mem_q[raddr];

endmodule

// File: rtl/commit_checker.sv
// In-order retirement checker: compares the core's commit stream against a preloaded table.
module commit_checker
  import commit_chk_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW:0]       num_expected,
  input  logic              exp_we,
  input  logic [AW-1:0]     exp_addr,
  input  logic [XLEN-1:0]   exp_pc,
  input  logic [4:0]        exp_rd,
  input  logic [XLEN-1:0]   exp_wdata,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic [4:0]        commit_rd,
  input  logic [XLEN-1:0]   commit_wdata,
  input  logic              commit_invalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [AW:0]       err_index,
  output logic [ERR_W-1:0]  err_kind,
  output logic [AW:0]       match_count,
  output logic [31:0]       cycle_count
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     num_q, num_d;
  logic [CW-1:0]     match_q, match_d;
  logic [CW-1:0]     err_index_q, err_index_d;
  logic [ERR_W-1:0]  err_kind_q, err_kind_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic [XLEN-1:0]   e_pc;
  logic [4:0]        e_rd;
  logic [XLEN-1:0]   e_wdata;
  logic [ERR_W-1:0]  chk_kind_c;
  logic [CW-1:0]     match_inc_c;
  logic              running_c;
  logic              start_ok_c;
  logic              tmo_hit_c;

  commit_exp_ram #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (exp_we && (state_q != ST_RUN)),
    .waddr(exp_addr),
    .wpc  (exp_pc),
    .wrd  (exp_rd),
    .wdata(exp_wdata),
    .raddr(match_q[AW-1:0]),
    .rpc  (e_pc),
    .rrd  (e_rd),
    .rdata(e_wdata)
  );

  assign running_c   = (state_q == ST_RUN);
  assign start_ok_c  = start && !running_c;
  assign match_inc_c = match_q + CW'(1);
  assign tmo_hit_c   = running_c && !commit_valid && ((tmo_q + TW'(1)) == TW'(TIMEOUT));

  // Classify the current commit against the awaited entry, highest priority first.
  always_comb begin
    chk_kind_c = ERR_NONE;
    if (commit_invalid) begin
      chk_kind_c = ERR_ILLEGAL;
    end else if (commit_pc != e_pc) begin
      chk_kind_c = ERR_PC;
    end else if (commit_rd != e_rd) begin
      chk_kind_c = ERR_RD;
    end else if ((e_rd != 5'd0) && (commit_wdata != e_wdata)) begin
      chk_kind_c = ERR_DATA;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (commit_valid) begin
          if (chk_kind_c != ERR_NONE) begin
            state_d = ST_FAIL;
          end else if (match_inc_c == num_q) begin
            state_d = ST_PASS;
          end
        end else if (tmo_hit_c) begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        if (start) begin
          state_d = (num_expected == CW'(0)) ? ST_PASS : ST_RUN;
        end
      end
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_PASS: begin done = 1'b1; pass = 1'b1; end
      ST_FAIL: begin done = 1'b1; fail = 1'b1; end
      default: ;
    endcase
  end

  // Counter and error-capture next values; a commit always clears the idle counter.
  always_comb begin
    num_d       = num_q;
    match_d     = match_q;
    err_index_d = err_index_q;
    err_kind_d  = err_kind_q;
    cyc_d       = cyc_q;
    tmo_d       = tmo_q;
    if (start_ok_c) begin
      num_d       = num_expected;
      match_d     = '0;
      err_index_d = '0;
      err_kind_d  = ERR_NONE;
      cyc_d       = '0;
      tmo_d       = '0;
    end else if (running_c) begin
      if (cyc_q != 32'hFFFF_FFFF) begin
        cyc_d = cyc_q + 32'd1;
      end
      if (commit_valid) begin
        tmo_d = '0;
        if (chk_kind_c != ERR_NONE) begin
          err_index_d = match_q;
          err_kind_d  = chk_kind_c;
        end else begin
          match_d = match_inc_c;
        end
      end else begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit_c) begin
          err_index_d = match_q;
          err_kind_d  = ERR_TIMEOUT;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q       <= '0;
      match_q     <= '0;
      err_index_q <= '0;
      err_kind_q  <= ERR_NONE;
      cyc_q       <= '0;
      tmo_q       <= '0;
    end else begin
      num_q       <= num_d;
      match_q     <= match_d;
      err_index_q <= err_index_d;
      err_kind_q  <= err_kind_d;
      cyc_q       <= cyc_d;
      tmo_q       <= tmo_d;
    end
  end

  assign err_index   = err_index_q;
  assign err_kind    = err_kind_q;
  assign match_count = match_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker with a cycle-level reference model and literal spot checks.
module tb_commit_checker;

  localparam int unsigned XLEN = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO = 8;
  localparam int unsigned AW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     num_expected = '0;
  logic            exp_we = 1'b0;
  logic [AW-1:0]   exp_addr = '0;
  logic [63:0]     exp_pc = '0;
  logic [4:0]      exp_rd = '0;
  logic [63:0]     exp_wdata = '0;
  logic            commit_valid = 1'b0;
  logic [63:0]     commit_pc = '0;
  logic [4:0]      commit_rd = '0;
  logic [63:0]     commit_wdata = '0;
  logic            commit_invalid = 1'b0;
  logic            busy, done, pass, fail;
  logic [AW:0]     err_index, match_count;
  logic [2:0]      err_kind;
  logic [31:0]     cycle_count;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  commit_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_expected(num_expected),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_pc(exp_pc), .exp_rd(exp_rd),
    .exp_wdata(exp_wdata), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .commit_invalid(commit_invalid),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .err_index(err_index),
    .err_kind(err_kind), .match_count(match_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] t_pc [DEPTH];
  logic [4:0]  t_rd [DEPTH];
  logic [63:0] t_wd [DEPTH];

  logic        m_busy, m_pass, m_fail;
  logic [AW:0] m_num, m_match, m_eidx;
  logic [2:0]  m_ekind;
  logic [31:0] m_cycle;
  int          m_idle;

  function automatic logic [2:0] judge(input int idx);
    if (commit_invalid) return 3'd1;
    if (commit_pc !== t_pc[idx]) return 3'd2;
    if (commit_rd !== t_rd[idx]) return 3'd3;
    if (t_rd[idx] != 5'd0 && commit_wdata !== t_wd[idx]) return 3'd4;
    return 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_pass <= 0; m_fail <= 0; m_num <= 0; m_match <= 0;
      m_eidx <= 0; m_ekind <= 0; m_cycle <= 0; m_idle <= 0;
    end else begin
      if (exp_we && !m_busy) begin
        t_pc[exp_addr] <= exp_pc;
        t_rd[exp_addr] <= exp_rd;
        t_wd[exp_addr] <= exp_wdata;
      end
      if (!m_busy && start) begin
        m_num <= num_expected; m_match <= 0; m_eidx <= 0; m_ekind <= 0;
        m_cycle <= 0; m_idle <= 0; m_fail <= 0;
        m_busy <= (num_expected != 0);
        m_pass <= (num_expected == 0);
      end else if (m_busy) begin
        if (m_cycle != 32'hFFFF_FFFF) m_cycle <= m_cycle + 1;
        if (commit_valid) begin
          m_idle <= 0;
          if (judge(int'(m_match)) != 0) begin
            m_busy <= 0; m_fail <= 1; m_eidx <= m_match; m_ekind <= judge(int'(m_match));
          end else begin
            m_match <= m_match + 1;
            if (int'(m_match) + 1 == int'(m_num)) begin m_busy <= 0; m_pass <= 1; end
          end
        end else begin
          m_idle <= m_idle + 1;
          if (m_idle + 1 == TMO) begin
            m_busy <= 0; m_fail <= 1; m_eidx <= m_match; m_ekind <= 3'd5;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_pass | m_fail));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("err_index", 32'(err_index), 32'(m_eidx));
      chk("err_kind", 32'(err_kind), 32'(m_ekind));
      chk("match_count", 32'(match_count), 32'(m_match));
      chk("cycle_count", cycle_count, m_cycle);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] d);
    exp_we = 1; exp_addr = AW'(a); exp_pc = pc; exp_rd = rd; exp_wdata = d;
    cyc();
    exp_we = 0;
  endtask

  task automatic start_run(input int n);
    start = 1; num_expected = (AW+1)'(n);
    cyc();
    start = 0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] d, input logic inv);
    commit_valid = 1; commit_pc = pc; commit_rd = rd; commit_wdata = d; commit_invalid = inv;
    cyc();
    commit_valid = 0; commit_invalid = 0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_eidx"}, 32'(err_index), 0);
    chk({tag, "_ekind"}, 32'(err_kind), 0);
    chk({tag, "_match"}, 32'(match_count), 0);
    chk({tag, "_cycles"}, cycle_count, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    outs_zero("reset");
    rst_n = 1;
    chk_en = 1;

    // Load the three-entry program.
    wr(0, 64'd0, 5'd1, 64'd16);
    wr(1, 64'd4, 5'd2, 64'd1234);
    wr(2, 64'd8, 5'd0, 64'h55);

    // Full pass; rd 0 entry ignores wdata.
    start_run(3);
    chk("t1_busy", 32'(busy), 1);
    commit(64'd0, 5'd1, 64'd16, 0);
    commit(64'd4, 5'd2, 64'd1234, 0);
    commit(64'd8, 5'd0, 64'hDEAD, 0);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_match", 32'(match_count), 3);
    chk("t1_cycles", cycle_count, 3);
    commit(64'h40, 5'd7, 64'd1, 0);
    chk("t1_extra_ignored", 32'(match_count), 3);

    // Data mismatch on entry 1.
    start_run(3);
    commit(64'd0, 5'd1, 64'd16, 0);
    commit(64'd4, 5'd2, 64'd1233, 0);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_kind", 32'(err_kind), 4);
    chk("t2_index", 32'(err_index), 1);
    chk("t2_match", 32'(match_count), 1);

    // Illegal outranks pc mismatch.
    start_run(3);
    commit(64'd0, 5'd1, 64'd16, 0);
    commit(64'h100, 5'd2, 64'd1234, 1);
    chk("t3_kind", 32'(err_kind), 1);
    chk("t3_index", 32'(err_index), 1);

    // rd mismatch.
    start_run(3);
    commit(64'd0, 5'd3, 64'd16, 0);
    chk("t3b_kind", 32'(err_kind), 3);

    // Timeout with no commits.
    start_run(3);
    repeat (TMO - 1) cyc();
    chk("t4_not_yet", 32'(fail), 0);
    cyc();
    chk("t4_fail", 32'(fail), 1);
    chk("t4_kind", 32'(err_kind), 5);
    chk("t4_index", 32'(err_index), 0);
    chk("t4_cycles", cycle_count, TMO);

    // Commit in the expiry cycle wins, then a later timeout reports entry 1.
    start_run(3);
    repeat (TMO - 1) cyc();
    commit(64'd0, 5'd1, 64'd16, 0);
    chk("t5_nofail", 32'(fail), 0);
    chk("t5_busy", 32'(busy), 1);
    repeat (TMO - 1) cyc();
    chk("t5_not_yet", 32'(fail), 0);
    cyc();
    chk("t5_fail", 32'(fail), 1);
    chk("t5_index", 32'(err_index), 1);

    // Zero-length run passes immediately.
    start_run(0);
    chk("t6_pass", 32'(pass), 1);
    chk("t6_busy", 32'(busy), 0);

    // Table write during RUN is dropped.
    start_run(3);
    wr(1, 64'h999, 5'd9, 64'd9);
    start = 1; num_expected = 5'd1;
    cyc();
    start = 0;
    chk("t7_start_ignored", 32'(busy), 1);
    commit(64'd0, 5'd1, 64'd16, 0);
    commit(64'd4, 5'd2, 64'd1234, 0);
    commit(64'd8, 5'd0, 64'd0, 0);
    chk("t7_pass", 32'(pass), 1);

    // Mid-run reset clears everything immediately; table survives.
    start_run(3);
    commit(64'd0, 5'd1, 64'd16, 0);
    commit(64'd4, 5'd2, 64'd1234, 0);
    chk("t8_match2", 32'(match_count), 2);
    rst_n = 0;
    #1;
    outs_zero("midreset");
    #1;
    rst_n = 1;
    cyc();
    start_run(3);
    commit(64'd0, 5'd1, 64'd16, 0);
    commit(64'd4, 5'd2, 64'd1234, 0);
    commit(64'd8, 5'd0, 64'hDEAD, 0);
    chk("t8_pass", 32'(pass), 1);
    chk("t8_match", 32'(match_count), 3);

    cyc();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/commit_checker.md
# commit_checker

Synthesizable, parametrised retirement checker for the single-cycle RV64 core. It watches the core's commit stream (PC, rd, write-back data, invalid flag) and compares it in order against a preloaded table of expected commits. It reports pass/fail, the first failing entry and the failure kind, and detects hangs with a no-commit timeout. It sits beside `ir_cpu` in simulation and FPGA bring-up, so the per-test hand-written `$display` checks are no longer needed.

## Interface
- `XLEN`, 64: data/PC width
- `DEPTH`, 16: expected-table entries (power of two, ≥2)
- `TIMEOUT`, 64: maximum consecutive cycles without `commit_valid` while running (≥1)
- `AW`, $clog2(DEPTH): table index width (derived, not overridden)

Ports:
- `clk` in 1: clock; all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: pulse; begins a check run
- `num_expected` in AW+1: number of table entries to check, 0..DEPTH; sampled on the accepted `start`
- `exp_we` in 1: expected-table write enable
- `exp_addr` in AW: table write index
- `exp_pc` in XLEN: expected commit PC
- `exp_rd` in 5: expected destination register
- `exp_wdata` in XLEN: expected write-back value
- `commit_valid` in 1: one instruction retires this cycle
- `commit_pc` in XLEN: PC of the retiring instruction
- `commit_rd` in 5: destination register
- `commit_wdata` in XLEN: value written to rd
- `commit_invalid` in 1: core flags the retiring instruction as invalid
- `busy` out 1: run in progress
- `done` out 1: verdict available (sticky)
- `pass` out 1: run completed with all entries matching
- `fail` out 1: run stopped on an error
- `err_index` out AW+1: index of the failing entry (timeout: index of the next awaited entry)
- `err_kind` out 3: 0 none, 1 illegal, 2 pc, 3 rd, 4 data, 5 timeout
- `match_count` out AW+1: entries matched so far
- `cycle_count` out 32: cycles spent in RUN, saturating at 2^32-1

## Operation
- The FSM has four states: IDLE, RUN, PASS, FAIL. Reset puts it in IDLE and drives every output to 0.
- IDLE/PASS/FAIL + `start`:
  - Latch `num_expected`.
  - Clear `match_count`, `cycle_count`, `err_*`, `done`, `pass`, `fail`, and the timeout counter.
  - Go to RUN. If `num_expected`==0, go directly to PASS instead.
- `start` in RUN is ignored.
- `exp_we` writes the table only when not in RUN. Writes during RUN are dropped.
- In RUN, a cycle with `commit_valid` checks entry `match_count`. Checks in priority order:
  - `commit_invalid` → illegal
  - pc ≠ exp_pc → pc
  - rd ≠ exp_rd → rd
  - exp_rd≠0 and wdata ≠ exp_wdata → data
  - When exp_rd==0 (and rd matched), wdata is not compared.
- Any mismatch: go to FAIL, set `err_index`=`match_count` and `err_kind`. `match_count` is not incremented.
- Match: increment `match_count`. If the new value equals the latched count, go to PASS.
- Timeout counter:
  - Resets on every `commit_valid` in RUN.
  - Increments on every RUN cycle without a commit.
  - Reaching TIMEOUT → FAIL, kind timeout.
- A commit and the timeout expiry in the same cycle: the commit wins, because the counter reset takes precedence.
- `commit_valid` outside RUN is ignored.
- Commits beyond `num_expected` arrive only after PASS and are ignored.
- `busy` = (state==RUN). `done` = PASS or FAIL. `pass`/`fail` are one-hot with `done`.

## Timing
- The table is written combinationally addressed and registered, so it is readable the cycle after `exp_we`.
- The table read is asynchronous, indexed by `match_count`, so the compare happens in the commit cycle.
- Verdict latency: a commit in cycle N updates `match_count`, `err_*`, and state at the edge ending cycle N. The result is visible in cycle N+1.
- `start` in cycle N → `busy`=1 in cycle N+1 (or `done`/`pass`=1 if `num_expected`==0).
- Timeout: with no commits after `busy` rises in cycle N, `fail` asserts in cycle N+TIMEOUT.
- `rst_n` low at any point, including mid-run, forces IDLE and zero outputs immediately. Table contents are not reset.
- `cycle_count` increments every RUN cycle, including the cycle of the final commit.

## Structure
- Package `commit_chk_pkg` holds:
  - the state enum (IDLE, RUN, PASS, FAIL);
  - the `err_kind` localparams ERR_NONE..ERR_TIMEOUT;
  - the `err_kind` width constant.
- Sub-module `commit_exp_ram` holds the DEPTH×(XLEN+5+XLEN) register array: one synchronous write port, one asynchronous read port, no reset.
- Top level contains the FSM, comparators, counters, and the timeout counter.

## Test plan
- Load 3 entries {pc 0 rd 1 data 16; pc 4 rd 2 data 1234; pc 8 rd 0 data x}, start with num_expected=3, drive matching commits on 3 consecutive cycles, the last with wdata=0xDEAD → `pass`=1 and `match_count`=3 one cycle after the third commit.
- Same table, second commit with wdata=1233 → `fail`=1, `err_kind`=4, `err_index`=1, `match_count`=1.
- Second commit with `commit_invalid`=1 and a wrong pc → `err_kind`=1 (priority check).
- TIMEOUT=8, start, no commits → `fail` in the 8th cycle after `busy` rises, `err_kind`=5, `err_index`=0. Repeat with a commit in exactly the expiry cycle → no fail.
- `num_expected`=0 → `pass` the cycle after `start`. `exp_we` during RUN leaves the entry unchanged (verify by a rerun).
- Assert `rst_n`=0 mid-run after 2 matches → all outputs 0 immediately. Rerun without reloading → same pass result.
